// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: F/A/M producer packets, the arbitrated writeback
// packet and the decode-side hold/statistics outputs.
interface wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              flush;

    logic              f_valid;
    logic [TAG_W-1:0]  f_dest;
    logic              f_we;
    logic [TAG_W-1:0]  f_ticket;
    logic [DATA_W-1:0] f_pc;
    logic [DATA_W-1:0] f_result;

    logic              a_valid;
    logic              a_ready;
    logic [TAG_W-1:0]  a_dest;
    logic              a_we;
    logic [TAG_W-1:0]  a_ticket;
    logic [DATA_W-1:0] a_pc;
    logic [DATA_W-1:0] a_result;

    logic              m_valid;
    logic              m_ready;
    logic [TAG_W-1:0]  m_dest;
    logic              m_we;
    logic [TAG_W-1:0]  m_ticket;
    logic [DATA_W-1:0] m_pc;
    logic [DATA_W-1:0] m_result;

    logic              wb_valid;
    logic [TAG_W-1:0]  wb_dest;
    logic              wb_we;
    logic [TAG_W-1:0]  wb_ticket;
    logic [DATA_W-1:0] wb_pc;
    logic [DATA_W-1:0] wb_result;
    logic [1:0]        wb_src;

    logic              f_issue_hold;
    logic [15:0]       f_conflict_cnt;

    modport master (
        output flush,
        output f_valid, f_dest, f_we, f_ticket, f_pc, f_result,
        output a_valid, a_dest, a_we, a_ticket, a_pc, a_result,
        output m_valid, m_dest, m_we, m_ticket, m_pc, m_result,
        input  a_ready, m_ready,
        input  wb_valid, wb_dest, wb_we, wb_ticket, wb_pc, wb_result, wb_src,
        input  f_issue_hold, f_conflict_cnt
    );

    modport slave (
        input  flush,
        input  f_valid, f_dest, f_we, f_ticket, f_pc, f_result,
        input  a_valid, a_dest, a_we, a_ticket, a_pc, a_result,
        input  m_valid, m_dest, m_we, m_ticket, m_pc, m_result,
        output a_ready, m_ready,
        output wb_valid, wb_dest, wb_we, wb_ticket, wb_pc, wb_result, wb_src,
        output f_issue_hold, f_conflict_cnt
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: F has absolute priority, A/M share round-robin,
// starvation of A/M raises f_issue_hold. Registered output, 1-cycle latency.
//
// rr state | meaning
// RR_A     | A wins an A/M tie
// RR_M     | M wins an A/M tie
module wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    wb_arbiter_if.slave   bus
);
    typedef enum logic {RR_A = 1'b0, RR_M = 1'b1} rr_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    rr_t               r_rr;
    rr_t               w_rr_next;
    logic              w_live;
    logic              w_grant_f;
    logic              w_grant_a;
    logic              w_grant_m;
    logic              w_conflict;
    logic [3:0]        r_starve_a;
    logic [3:0]        r_starve_m;
    logic [3:0]        w_starve_a_next;
    logic [3:0]        w_starve_m_next;

    logic              r_wb_valid;
    logic [TAG_W-1:0]  r_wb_dest;
    logic              r_wb_we;
    logic [TAG_W-1:0]  r_wb_ticket;
    logic [DATA_W-1:0] r_wb_pc;
    logic [DATA_W-1:0] r_wb_result;
    logic [1:0]        r_wb_src;
    logic              r_hold;
    logic [15:0]       r_conflict_cnt;

    // No grant during reset so a producer never sees a phantom transfer.
    always_comb begin
        w_live    = !i_reset && !bus.flush;
        w_grant_f = w_live && bus.f_valid;
        w_grant_a = w_live && !bus.f_valid && bus.a_valid &&
                    (!bus.m_valid || (r_rr == RR_A));
        w_grant_m = w_live && !bus.f_valid && bus.m_valid &&
                    (!bus.a_valid || (r_rr == RR_M));
        w_conflict = bus.f_valid && !bus.flush && (bus.a_valid || bus.m_valid);
    end

    always_comb begin
        w_rr_next = r_rr;
        if (bus.flush) begin
            w_rr_next = RR_A;
        end else if (w_grant_a) begin
            w_rr_next = RR_M;
        end else if (w_grant_m) begin
            w_rr_next = RR_A;
        end
    end

    always_comb begin
        w_starve_a_next = 4'd0;
        w_starve_m_next = 4'd0;
        if (!bus.flush && bus.a_valid && !w_grant_a) begin
            w_starve_a_next = (r_starve_a >= LP_STARVE_MAX) ? LP_STARVE_MAX : r_starve_a + 4'd1;
        end
        if (!bus.flush && bus.m_valid && !w_grant_m) begin
            w_starve_m_next = (r_starve_m >= LP_STARVE_MAX) ? LP_STARVE_MAX : r_starve_m + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rr       <= RR_A;
            r_starve_a <= 4'd0;
            r_starve_m <= 4'd0;
        end else begin
            r_rr       <= w_rr_next;
            r_starve_a <= w_starve_a_next;
            r_starve_m <= w_starve_m_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb_valid     <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_we        <= 1'b0;
            r_wb_ticket    <= '0;
            r_wb_pc        <= '0;
            r_wb_result    <= '0;
            r_wb_src       <= 2'b00;
            r_hold         <= 1'b0;
            r_conflict_cnt <= 16'd0;
        end else begin
            r_hold <= !bus.flush && ((w_starve_a_next == LP_STARVE_MAX) ||
                                     (w_starve_m_next == LP_STARVE_MAX));
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            // Data fields only load on a grant; they hold while wb_valid=0.
            if (w_grant_f) begin
                r_wb_valid  <= 1'b1;
                r_wb_src    <= 2'b01;
                r_wb_dest   <= bus.f_dest;
                r_wb_we     <= bus.f_we;
                r_wb_ticket <= bus.f_ticket;
                r_wb_pc     <= bus.f_pc;
                r_wb_result <= bus.f_result;
            end else if (w_grant_a) begin
                r_wb_valid  <= 1'b1;
                r_wb_src    <= 2'b10;
                r_wb_dest   <= bus.a_dest;
                r_wb_we     <= bus.a_we;
                r_wb_ticket <= bus.a_ticket;
                r_wb_pc     <= bus.a_pc;
                r_wb_result <= bus.a_result;
            end else if (w_grant_m) begin
                r_wb_valid  <= 1'b1;
                r_wb_src    <= 2'b11;
                r_wb_dest   <= bus.m_dest;
                r_wb_we     <= bus.m_we;
                r_wb_ticket <= bus.m_ticket;
                r_wb_pc     <= bus.m_pc;
                r_wb_result <= bus.m_result;
            end else begin
                r_wb_valid  <= 1'b0;
                r_wb_src    <= 2'b00;
            end
        end
    end

    assign bus.a_ready        = w_grant_a;
    assign bus.m_ready        = w_grant_m;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.wb_dest        = r_wb_dest;
    assign bus.wb_we          = r_wb_we;
    assign bus.wb_ticket      = r_wb_ticket;
    assign bus.wb_pc          = r_wb_pc;
    assign bus.wb_result      = r_wb_result;
    assign bus.wb_src         = r_wb_src;
    assign bus.f_issue_hold   = r_hold;
    assign bus.f_conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_arbiter;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    wb_arbiter #(.DATA_W(DW), .TAG_W(TW), .STARVE_MAX(SMAX)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          e_valid, e_we, e_hold;
    logic [1:0]    e_src;
    logic [TW-1:0] e_dest, e_ticket;
    logic [DW-1:0] e_pc, e_res;
    int            e_conf;
    int            starve_a, starve_m;
    logic          m_last_was_a;   // 1: A was served last among A/M, so M wins a tie
    logic          a_took, m_took;

    task automatic model_reset();
        e_valid = 0; e_we = 0; e_hold = 0; e_src = 0;
        e_dest = 0; e_ticket = 0; e_pc = 0; e_res = 0;
        e_conf = 0; starve_a = 0; starve_m = 0; m_last_was_a = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic gf, ga, gm;
        a_took = 0;
        m_took = 0;
        if (rst) begin
            model_reset();
            chk("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
            chk("rst_wb_src", 32'(bus.wb_src), 32'(0));
            chk("rst_hold", 32'(bus.f_issue_hold), 32'(0));
            chk("rst_conf", 32'(bus.f_conflict_cnt), 32'(0));
            chk("rst_a_ready", 32'(bus.a_ready), 32'(0));
            chk("rst_m_ready", 32'(bus.m_ready), 32'(0));
        end else begin
            chk("wb_valid", 32'(bus.wb_valid), 32'(e_valid));
            chk("wb_src", 32'(bus.wb_src), 32'(e_src));
            chk("wb_dest", 32'(bus.wb_dest), 32'(e_dest));
            chk("wb_we", 32'(bus.wb_we), 32'(e_we));
            chk("wb_ticket", 32'(bus.wb_ticket), 32'(e_ticket));
            chk("wb_pc", 32'(bus.wb_pc), 32'(e_pc));
            chk("wb_result", 32'(bus.wb_result), 32'(e_res));
            chk("f_issue_hold", 32'(bus.f_issue_hold), 32'(e_hold));
            chk("f_conflict_cnt", 32'(bus.f_conflict_cnt), 32'(e_conf));

            gf = !bus.flush && bus.f_valid;
            ga = 0; gm = 0;
            if (!bus.flush && !bus.f_valid) begin
                if (bus.a_valid && bus.m_valid) begin
                    ga = !m_last_was_a;
                    gm = m_last_was_a;
                end else begin
                    ga = bus.a_valid;
                    gm = bus.m_valid;
                end
            end
            chk("a_ready", 32'(bus.a_ready), 32'(ga));
            chk("m_ready", 32'(bus.m_ready), 32'(gm));
            a_took = bus.a_valid && bus.a_ready;
            m_took = bus.m_valid && bus.m_ready;

            if (bus.f_valid && !bus.flush && (bus.a_valid || bus.m_valid) && e_conf < 16'hFFFF)
                e_conf++;
            starve_a = (!bus.flush && bus.a_valid && !ga) ? ((starve_a + 1 > SMAX) ? SMAX : starve_a + 1) : 0;
            starve_m = (!bus.flush && bus.m_valid && !gm) ? ((starve_m + 1 > SMAX) ? SMAX : starve_m + 1) : 0;
            e_hold = !bus.flush && (starve_a == SMAX || starve_m == SMAX);
            if (bus.flush) m_last_was_a = 0;
            else if (ga) m_last_was_a = 1;
            else if (gm) m_last_was_a = 0;

            e_valid = gf || ga || gm;
            if (gf) begin
                e_src = 2'b01; e_dest = bus.f_dest; e_we = bus.f_we;
                e_ticket = bus.f_ticket; e_pc = bus.f_pc; e_res = bus.f_result;
            end else if (ga) begin
                e_src = 2'b10; e_dest = bus.a_dest; e_we = bus.a_we;
                e_ticket = bus.a_ticket; e_pc = bus.a_pc; e_res = bus.a_result;
            end else if (gm) begin
                e_src = 2'b11; e_dest = bus.m_dest; e_we = bus.m_we;
                e_ticket = bus.m_ticket; e_pc = bus.m_pc; e_res = bus.m_result;
            end else begin
                e_src = 2'b00;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic rand_f();
        bus.f_dest = 3'($urandom); bus.f_ticket = 3'($urandom); bus.f_we = 1'($urandom);
        bus.f_pc = 16'($urandom); bus.f_result = 16'($urandom);
    endtask

    task automatic rand_a();
        bus.a_dest = 3'($urandom); bus.a_ticket = 3'($urandom); bus.a_we = 1'($urandom);
        bus.a_pc = 16'($urandom); bus.a_result = 16'($urandom);
    endtask

    task automatic rand_m();
        bus.m_dest = 3'($urandom); bus.m_ticket = 3'($urandom); bus.m_we = 1'($urandom);
        bus.m_pc = 16'($urandom); bus.m_result = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_src [4];
        int f_burst;
        exp_src[0] = 2'b10; exp_src[1] = 2'b11; exp_src[2] = 2'b10; exp_src[3] = 2'b11;
        bus.flush = 0; bus.f_valid = 0; bus.a_valid = 0; bus.m_valid = 0;
        rand_f(); rand_a(); rand_m();
        tick(); tick();
        rst = 0;

        // Single A request
        tick();
        bus.a_valid = 1; bus.a_dest = 3; bus.a_ticket = 5; bus.a_result = 16'h00AA;
        mid();
        chk("t1_a_ready", 32'(bus.a_ready), 32'(1));
        tick();
        bus.a_valid = 0;
        chk("t1_wb_valid", 32'(bus.wb_valid), 32'(1));
        chk("t1_wb_src", 32'(bus.wb_src), 32'(2));
        chk("t1_wb_dest", 32'(bus.wb_dest), 32'(3));
        chk("t1_wb_ticket", 32'(bus.wb_ticket), 32'(5));
        chk("t1_wb_result", 32'(bus.wb_result), 32'(16'h00AA));

        // M alone (points rr back at A), then A and M together for 4 cycles
        bus.m_valid = 1; rand_m();
        tick();
        chk("t2_m_alone_src", 32'(bus.wb_src), 32'(3));
        bus.a_valid = 1; rand_a();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_rr_src", 32'(bus.wb_src), 32'(exp_src[i]));
            if (i == 3) begin bus.a_valid = 0; bus.m_valid = 0; end
        end

        // F, A, M in the same cycle
        bus.f_valid = 1; bus.a_valid = 1; bus.m_valid = 1;
        rand_f(); rand_a(); rand_m();
        mid();
        chk("t3_a_ready", 32'(bus.a_ready), 32'(0));
        chk("t3_m_ready", 32'(bus.m_ready), 32'(0));
        tick();
        bus.f_valid = 0; bus.a_valid = 0; bus.m_valid = 0;
        chk("t3_wb_src", 32'(bus.wb_src), 32'(1));
        chk("t3_conf", 32'(bus.f_conflict_cnt), 32'(1));
        tick();

        // F held 6 cycles while A waits
        rand_a();
        for (int k = 1; k <= 8; k++) begin
            bus.f_valid = (k <= 6);
            bus.a_valid = (k <= 7);
            rand_f();
            mid();
            chk("t4_hold", 32'(bus.f_issue_hold), 32'((k >= 5 && k <= 7) ? 1 : 0));
            if (k == 7) chk("t4_a_grant", 32'(bus.a_ready), 32'(1));
            if (k == 8) chk("t4_conf", 32'(bus.f_conflict_cnt), 32'(7));
            tick();
        end

        // Flush while A valid
        bus.flush = 1; bus.a_valid = 1; rand_a();
        mid();
        chk("t5_a_ready_flush", 32'(bus.a_ready), 32'(0));
        tick();
        bus.flush = 0;
        mid();
        chk("t5_wb_valid", 32'(bus.wb_valid), 32'(0));
        chk("t5_hold", 32'(bus.f_issue_hold), 32'(0));
        chk("t5_a_ready", 32'(bus.a_ready), 32'(1));
        tick();
        bus.a_valid = 0;
        chk("t5_wb_src", 32'(bus.wb_src), 32'(2));

        // Async reset while wb_valid=1
        bus.a_valid = 1; rand_a();
        tick();
        bus.a_valid = 0;
        chk("t6_pre_wb_valid", 32'(bus.wb_valid), 32'(1));
        #1 rst = 1;
        #1;
        chk("t6_wb_valid", 32'(bus.wb_valid), 32'(0));
        chk("t6_hold", 32'(bus.f_issue_hold), 32'(0));
        chk("t6_conf", 32'(bus.f_conflict_cnt), 32'(0));
        tick();
        rst = 0;
        bus.a_valid = 1; bus.m_valid = 1; rand_a(); rand_m();
        mid();
        chk("t6_rr_a", 32'(bus.a_ready), 32'(1));
        chk("t6_rr_m", 32'(bus.m_ready), 32'(0));
        tick();

        // Randomized traffic
        f_burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.a_valid && !a_took)) begin
                bus.a_valid = ($urandom_range(0, 99) < 60);
                rand_a();
            end
            if (!(bus.m_valid && !m_took)) begin
                bus.m_valid = ($urandom_range(0, 99) < 60);
                rand_m();
            end
            if (f_burst > 0) begin
                bus.f_valid = 1;
                f_burst--;
            end else if ($urandom_range(0, 99) < 6) begin
                bus.f_valid = 1;
                f_burst = $urandom_range(2, 8);
            end else begin
                bus.f_valid = ($urandom_range(0, 99) < 25);
            end
            rand_f();
            bus.flush = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 999) < 3) begin
                #2 rst = 1;
                tick();
                rst = 0;
            end
            tick();
        end

        bus.flush = 0; bus.f_valid = 0; bus.a_valid = 0; bus.m_valid = 0;
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
